// File: rtl/note_display_pkg.sv
// Shared types and constants for the multiplexed note display: scan states,
// note codes and their active-low 7-segment patterns ({G,F,E,D,C,B,A}).
package note_display_pkg;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        GAP  = 2'd1,
        SHOW = 2'd2
    } state_e;

    localparam logic [3:0] NOTE_A     = 4'h0;
    localparam logic [3:0] NOTE_E     = 4'h1;
    localparam logic [3:0] NOTE_B     = 4'h2;
    localparam logic [3:0] NOTE_G     = 4'h3;
    localparam logic [3:0] NOTE_D     = 4'h4;
    localparam logic [3:0] NOTE_H     = 4'h5;
    localparam logic [3:0] NOTE_L     = 4'h6;
    localparam logic [3:0] NOTE_BLANK = 4'h7;
    localparam logic [3:0] NOTE_I     = 4'h8;
    localparam logic [3:0] NOTE_O     = 4'h9;

    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_G     = 7'b0010000;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_H     = 7'b0001001;
    localparam logic [6:0] SEG_L     = 7'b1000111;
    localparam logic [6:0] SEG_I     = 7'b1111001;
    localparam logic [6:0] SEG_O     = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/note_seg_decode.sv
// Combinational note code -> active-low 7-segment pattern; codes 7 and 10..15
// are blank.
module note_seg_decode
    import note_display_pkg::*;
(
    input  logic [3:0] code_i,
    output logic [6:0] seg_n_o
);

    always_comb begin
        // NOTE: default assigned first so every path drives seg_n_o and no latch is inferred.
        seg_n_o = SEG_BLANK;
        case (code_i)
            NOTE_A:     seg_n_o = SEG_A;
            NOTE_E:     seg_n_o = SEG_E;
            NOTE_B:     seg_n_o = SEG_B;
            NOTE_G:     seg_n_o = SEG_G;
            NOTE_D:     seg_n_o = SEG_D;
            NOTE_H:     seg_n_o = SEG_H;
            NOTE_L:     seg_n_o = SEG_L;
            NOTE_BLANK: seg_n_o = SEG_BLANK;
            NOTE_I:     seg_n_o = SEG_I;
            NOTE_O:     seg_n_o = SEG_O;
            default:    seg_n_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/note_display_scan.sv
// Time-multiplexed multi-digit note display: shadow-latched codes, per-digit
// blanking gap, registered seg/an/dp. Optional blinking via NOTE_DISPLAY_BLINK_EN.
module note_display_scan
    import note_display_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 100000,
    parameter int GAP_CYCLES   = 2,
`ifdef NOTE_DISPLAY_BLINK_EN
    parameter int BLINK_ROUNDS = 64,
`endif
    parameter int ACTIVE_LOW   = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [4*NUM_DIGITS-1:0]   codes,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic                      load,
`ifdef NOTE_DISPLAY_BLINK_EN
    input  logic [NUM_DIGITS-1:0]     blink,
`endif
    output logic [6:0]                seg,
    output logic                      dp,
    output logic [NUM_DIGITS-1:0]     an
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PRE_W = $clog2(SCAN_DIV + 1);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic             INV      = (ACTIVE_LOW == 0);

    state_e                         state_q, state_d;
    logic [IDX_W-1:0]               idx_q, idx_d;
    logic [PRE_W-1:0]               pre_q, pre_d;
    logic [GAP_W-1:0]               gap_q, gap_d;
    logic [NUM_DIGITS-1:0][3:0]     codes_q, codes_d;
    logic [NUM_DIGITS-1:0]          dps_q, dps_d;
    logic [6:0]                     seg_q;
    logic [NUM_DIGITS-1:0]          an_q;
    logic                           dp_q;

    // Active-low view of the outputs; polarity is applied at the output registers.
    logic [6:0]                     seg_n, dec_seg_n;
    logic [NUM_DIGITS-1:0]          an_n;
    logic                           dp_n;
    logic                           blank_digit;

    note_seg_decode u_decode (
        .code_i  (codes_q[idx_q]),
        .seg_n_o (dec_seg_n)
    );

`ifdef NOTE_DISPLAY_BLINK_EN
    localparam int RND_W = $clog2(BLINK_ROUNDS + 1);

    logic [RND_W-1:0] rounds_q;
    logic             phase_q;
    logic             round_wrap;

    assign round_wrap  = (state_q == SHOW) && (pre_q == PRE_LAST) && (idx_q == IDX_LAST);
    assign blank_digit = phase_q && blink[idx_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            rounds_q <= '0;
            phase_q  <= 1'b0;
        end else if (round_wrap) begin
            if (rounds_q == RND_W'(BLINK_ROUNDS - 1)) begin
                rounds_q <= '0;
                phase_q  <= ~phase_q;
            end else begin
                rounds_q <= rounds_q + RND_W'(1);
            end
        end
    end
`else
    assign blank_digit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pre_d   = pre_q;
        gap_d   = gap_q;
        codes_d = codes_q;
        dps_d   = dps_q;
        seg_n   = SEG_BLANK;
        an_n    = '1;
        dp_n    = 1'b1;

        // The shadow follows load in every state; only OFF also starts the scan.
        if (load) begin
            codes_d = codes;
            dps_d   = dp_in;
        end

        case (state_q)
            OFF: begin
                pre_d = '0;
                gap_d = '0;
                if (load) begin
                    state_d = GAP;
                    idx_d   = '0;
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    gap_d   = '0;
                    state_d = SHOW;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            SHOW: begin
                an_n[idx_q] = 1'b0;
                if (!blank_digit) begin
                    seg_n = dec_seg_n;
                    dp_n  = ~dps_q[idx_q];
                end
                if (pre_q == PRE_LAST) begin
                    pre_d   = '0;
                    state_d = GAP;
                    idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
                end else begin
                    pre_d = pre_q + PRE_W'(1);
                end
            end
            default: state_d = OFF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= OFF;
            idx_q   <= '0;
            pre_q   <= '0;
            gap_q   <= '0;
            // NOTE: the shadow storage is reset so a fresh start shows blanks, not stale codes.
            codes_q <= '1;
            dps_q   <= '0;
            seg_q   <= {7{~INV}};
            an_q    <= {NUM_DIGITS{~INV}};
            dp_q    <= ~INV;
        end else begin
            // NOTE: non-blocking so every register here sees the pre-edge values of the others.
            state_q <= state_d;
            idx_q   <= idx_d;
            pre_q   <= pre_d;
            gap_q   <= gap_d;
            codes_q <= codes_d;
            dps_q   <= dps_d;
            seg_q   <= seg_n ^ {7{INV}};
            an_q    <= an_n ^ {NUM_DIGITS{INV}};
            dp_q    <= dp_n ^ INV;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_note_display_scan.sv
// Bench for note_display_scan (4 digits, SCAN_DIV=4, GAP_CYCLES=1, active-low):
// decode table vectors, hand-written scan sequences, and a random run against a timeline model.
module tb_note_display_scan;

    localparam int ND = 4;
    localparam int SD = 4;
    localparam int GC = 1;
    localparam int P  = SD + GC;
    localparam logic [11:0] ALL_OFF = {7'b1111111, 4'b1111, 1'b1};

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [4*ND-1:0] codes = '0;
    logic [ND-1:0]   dp_in = '0;
    logic            load = 1'b0;
    logic [6:0]      seg;
    logic            dp;
    logic [ND-1:0]   an;

    int n_checks = 0;
    int n_pass   = 0;
    bit check_model = 1'b0;

    // Timeline model: once started, output k edges later reflects t = k-1 cycles into the scan.
    bit          m_run = 1'b0;
    int          m_t   = 0;
    logic [3:0]  m_code [ND];
    logic        m_dp   [ND];
    logic [11:0] m_exp;

    note_display_scan #(
        .NUM_DIGITS (ND),
        .SCAN_DIV   (SD),
        .GAP_CYCLES (GC),
        .ACTIVE_LOW (1)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .codes (codes),
        .dp_in (dp_in),
        .load  (load),
        .seg   (seg),
        .dp    (dp),
        .an    (an)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got seg=%b an=%b dp=%b, required seg=%b an=%b dp=%b",
                      name, act[11:5], act[4:1], act[0], exp[11:5], exp[4:1], exp[0]);
    endtask

    function automatic logic [6:0] spec_decode(input logic [3:0] c);
        case (c)
            4'd0:    return 7'b0001000;
            4'd1:    return 7'b0000110;
            4'd2:    return 7'b0000011;
            4'd3:    return 7'b0010000;
            4'd4:    return 7'b0100001;
            4'd5:    return 7'b0001001;
            4'd6:    return 7'b1000111;
            4'd8:    return 7'b1111001;
            4'd9:    return 7'b1000000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [11:0] model_out();
        int d;
        logic [3:0] an_e;
        if (!m_run || (m_t % P) < GC) return ALL_OFF;
        d = (m_t / P) % ND;
        an_e = 4'b1111;
        an_e[d] = 1'b0;
        return {spec_decode(m_code[d]), an_e, ~m_dp[d]};
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_exp = ALL_OFF;
            m_run = 1'b0;
            m_t   = 0;
            for (int i = 0; i < ND; i++) begin
                m_code[i] = 4'hF;
                m_dp[i]   = 1'b0;
            end
        end else begin
            m_exp = model_out();
            if (m_run) m_t++;
            if (load) begin
                for (int i = 0; i < ND; i++) begin
                    m_code[i] = codes[4*i +: 4];
                    m_dp[i]   = dp_in[i];
                end
                if (!m_run) begin
                    m_run = 1'b1;
                    m_t   = 0;
                end
            end
        end
        #1;
        if (check_model) check("model", {seg, an, dp}, m_exp);
    endtask

    task automatic expect_n(input string name, input int n, input logic [6:0] s,
                            input logic [3:0] a, input logic d);
        repeat (n) begin
            tick();
            check(name, {seg, an, dp}, {s, a, d});
        end
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        load = 1'b0;
        tick();
        rst  = 1'b0;
    endtask

    task automatic do_load(input logic [15:0] c, input logic [3:0] d);
        codes = c;
        dp_in = d;
        load  = 1'b1;
        tick();
        load  = 1'b0;
    endtask

    typedef struct {
        logic [3:0] code;
        logic       dp_req;
        logic [6:0] exp_seg;
        logic       exp_dp;
    } vec_t;

    vec_t vecs [16];

    initial begin
        logic [3:0] dpv;
        logic [3:0] an_e;

        vecs[0]  = '{4'h0, 1'b0, 7'b0001000, 1'b1};
        vecs[1]  = '{4'h1, 1'b1, 7'b0000110, 1'b0};
        vecs[2]  = '{4'h2, 1'b0, 7'b0000011, 1'b1};
        vecs[3]  = '{4'h3, 1'b1, 7'b0010000, 1'b0};
        vecs[4]  = '{4'h4, 1'b0, 7'b0100001, 1'b1};
        vecs[5]  = '{4'h5, 1'b1, 7'b0001001, 1'b0};
        vecs[6]  = '{4'h6, 1'b0, 7'b1000111, 1'b1};
        vecs[7]  = '{4'h7, 1'b1, 7'b1111111, 1'b0};
        vecs[8]  = '{4'h8, 1'b0, 7'b1111001, 1'b1};
        vecs[9]  = '{4'h9, 1'b1, 7'b1000000, 1'b0};
        vecs[10] = '{4'hA, 1'b0, 7'b1111111, 1'b1};
        vecs[11] = '{4'hB, 1'b1, 7'b1111111, 1'b0};
        vecs[12] = '{4'hC, 1'b0, 7'b1111111, 1'b1};
        vecs[13] = '{4'hD, 1'b1, 7'b1111111, 1'b0};
        vecs[14] = '{4'hE, 1'b0, 7'b1111111, 1'b1};
        vecs[15] = '{4'hF, 1'b1, 7'b1111111, 1'b0};

        // Idle after reset: everything dark until the first load.
        do_reset();
        check("reset", {seg, an, dp}, ALL_OFF);
        expect_n("idle", 30, 7'b1111111, 4'b1111, 1'b1);

        // Decode table, digit 0 after load + gap.
        for (int i = 0; i < 16; i++) begin
            do_reset();
            do_load({12'hFFF, vecs[i].code}, {3'b000, vecs[i].dp_req});
            tick();
            tick();
            check($sformatf("decode_%0d", i), {seg, an, dp}, {vecs[i].exp_seg, 4'b1110, vecs[i].exp_dp});
        end

        // Full round of 16'h9810, wrapping back to digit 0.
        do_reset();
        do_load(16'h9810, 4'b0000);
        check("load_off", {seg, an, dp}, ALL_OFF);
        expect_n("gap0", 1, 7'b1111111, 4'b1111, 1'b1);
        expect_n("dig0_A", 4, 7'b0001000, 4'b1110, 1'b1);
        expect_n("gap1", 1, 7'b1111111, 4'b1111, 1'b1);
        expect_n("dig1_E", 4, 7'b0000110, 4'b1101, 1'b1);
        expect_n("gap2", 1, 7'b1111111, 4'b1111, 1'b1);
        expect_n("dig2_I", 4, 7'b1111001, 4'b1011, 1'b1);
        expect_n("gap3", 1, 7'b1111111, 4'b1111, 1'b1);
        expect_n("dig3_O", 4, 7'b1000000, 4'b0111, 1'b1);
        expect_n("gap_wrap", 1, 7'b1111111, 4'b1111, 1'b1);
        expect_n("wrap_A", 1, 7'b0001000, 4'b1110, 1'b1);

        // Blank codes with decimal points on digits 0 and 2.
        do_reset();
        dpv = 4'b0101;
        do_load(16'hFEDA, dpv);
        for (int d = 0; d < ND; d++) begin
            an_e = 4'b1111;
            an_e[d] = 1'b0;
            expect_n("blank_gap", 1, 7'b1111111, 4'b1111, 1'b1);
            expect_n($sformatf("blank_dig%0d", d), 4, 7'b1111111, an_e, ~dpv[d]);
        end

        // Reload during digit 1's SHOW, then reload on a terminal count.
        do_reset();
        do_load(16'h9810, 4'b0000);
        repeat (6) tick();
        expect_n("pre_reload", 1, 7'b0000110, 4'b1101, 1'b1);
        codes = 16'h9850;
        load  = 1'b1;
        tick();
        load  = 1'b0;
        check("reload_edge", {seg, an, dp}, {7'b0000110, 4'b1101, 1'b1});
        expect_n("reload_H", 2, 7'b0001001, 4'b1101, 1'b1);
        expect_n("reload_gap", 1, 7'b1111111, 4'b1111, 1'b1);
        expect_n("reload_dig2", 3, 7'b1111001, 4'b1011, 1'b1);
        codes = 16'h5850;
        load  = 1'b1;
        tick();
        load  = 1'b0;
        check("tc_load_dig2", {seg, an, dp}, {7'b1111001, 4'b1011, 1'b1});
        expect_n("tc_load_gap", 1, 7'b1111111, 4'b1111, 1'b1);
        expect_n("tc_load_dig3", 4, 7'b0001001, 4'b0111, 1'b1);

        // Reset mid-SHOW of digit 2, stay dark, restart at digit 0 with new codes.
        do_reset();
        do_load(16'h9810, 4'b0000);
        repeat (12) tick();
        expect_n("pre_rst_dig2", 1, 7'b1111001, 4'b1011, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst", {seg, an, dp}, ALL_OFF);
        expect_n("post_rst_idle", 10, 7'b1111111, 4'b1111, 1'b1);
        do_load(16'h0123, 4'b0000);
        check("restart_load", {seg, an, dp}, ALL_OFF);
        expect_n("restart_gap", 1, 7'b1111111, 4'b1111, 1'b1);
        expect_n("restart_dig0_g", 4, 7'b0010000, 4'b1110, 1'b1);

        // Random loads and resets against the timeline model.
        do_reset();
        check_model = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            rst   = ($urandom_range(0, 299) == 0);
            load  = ($urandom_range(0, 11) == 0);
            codes = 16'($urandom);
            dp_in = 4'($urandom_range(0, 15));
            tick();
        end
        check_model = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
